serial_fs: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: d = a - b, computed LSB-first, one bit per clock.

---
 rtl/serial_fs_if.sv | 23 ++
 rtl/serial_fs.sv | 133 +++++++++++++
 tb/tb_serial_fs.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_fs_if.sv
// Handshake and operand/result bundle between a controlling FSM (master)
// and the bit-serial subtractor (slave).
interface serial_fs_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output start, a, b,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bo
    );
endinterface

// File: rtl/serial_fs.sv
// Bit-serial WIDTH-bit subtractor: d = a - b, LSB first, one bit per clock,
// through a single full-subtractor cell with a registered borrow.
module serial_fs #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_fs_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {borrow_out, difference_bit} for one bit position.
    function automatic logic [1:0] fs_cell(input logic a0, input logic b0, input logic bin);
        logic dbit;
        logic brn;
        dbit = a0 ^ b0 ^ bin;
        brn  = (~a0 & b0) | (~a0 & bin) | (b0 & bin);
        return {brn, dbit};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             dbit_s;
    logic             brn_s;
    logic [WIDTH-1:0] d_shift_s;

    assign {brn_s, dbit_s} = fs_cell(a_sr_q[0], b_sr_q[0], br_q);

    // A one-bit datapath has no older bits to shift down.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_shift_s = dbit_s;
        end else begin : g_wn
            assign d_shift_s = {dbit_s, d_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bo_d    = bo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_sr_d = d_shift_s;
                a_sr_d = a_sr_q >> 1'b1;
                b_sr_d = b_sr_q >> 1'b1;
                br_d   = brn_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    d_d     = d_shift_s;
                    bo_d    = brn_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags follow the upcoming state so they stay purely registered.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
endmodule

// File: tb/tb_serial_fs.sv
// Directed bench for serial_fs: WIDTH=8 instance for handshake/latency and
// corner operands, WIDTH=4 instance for an exhaustive operand sweep.
module tb_serial_fs;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    serial_fs_if #(.WIDTH(8)) if8 ();
    serial_fs_if #(.WIDTH(4)) if4 ();

    serial_fs #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_fs #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full 8-bit operation with latency and hold checks.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
        int early;
        @(negedge clk);
        if8.start = 1'b1; if8.a = av; if8.b = bv;
        @(posedge clk); #1;
        chk({tag, "_busy_E0"}, 32'(if8.busy), 32'd1);
        @(negedge clk);
        if8.start = 1'b0; if8.a = ~av; if8.b = 8'h5A;
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (if8.done !== 1'b0 || if8.busy !== 1'b1) early++;
        end
        chk({tag, "_run_flags"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_E8"}, 32'(if8.done), 32'd1);
        chk({tag, "_d"}, 32'(if8.d), 32'(ed));
        chk({tag, "_bo"}, 32'(if8.bo), 32'(eb));
        chk({tag, "_busy_E8"}, 32'(if8.busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_E9"}, 32'(if8.done), 32'd0);
        chk({tag, "_busy_E9"}, 32'(if8.busy), 32'd0);
        chk({tag, "_d_hold"}, 32'(if8.d), 32'(ed));
    endtask

    initial begin
        int dones;
        int done_k;
        logic [7:0] d_at_done;
        int got;
        logic [3:0] ea;
        logic [3:0] eb4;

        n_assert = 0;
        n_fail   = 0;
        if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00;
        if4.start = 1'b0; if4.a = 4'h0;  if4.b = 4'h0;
        rst = 1'b0;

        // Reset asserted between edges; outputs clear before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_d", 32'(if8.d), 32'd0);
        chk("rst_bo", 32'(if8.bo), 32'd0);
        chk("rst_d4", 32'(if4.d), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op8("sub_100_37", 8'd100, 8'd37, 8'd63, 1'b0);
        op8("sub_37_100", 8'd37, 8'd100, 8'hC1, 1'b1);
        op8("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        op8("sub_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        op8("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        op8("sub_80_7F", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Start held with new operands through RUN and DONE.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd10; if8.b = 8'd3;
        @(posedge clk); #1;
        chk("retrig_busy_E0", 32'(if8.busy), 32'd1);
        @(negedge clk);
        if8.a = 8'd200; if8.b = 8'd1;
        dones = 0; done_k = 0; d_at_done = 8'h00;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (if8.done === 1'b1) begin
                dones++;
                done_k = k;
                d_at_done = if8.d;
            end
        end
        chk("retrig_done_count", 32'(dones), 32'd1);
        chk("retrig_done_edge", 32'(done_k), 32'd8);
        chk("retrig_d", 32'(d_at_done), 32'd7);
        chk("retrig_busy_E9", 32'(if8.busy), 32'd0);
        @(posedge clk); #1;
        chk("restart_busy_E10", 32'(if8.busy), 32'd1);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk); #1;
        chk("restart_done", 32'(if8.done), 32'd1);
        chk("restart_d", 32'(if8.d), 32'd199);
        chk("restart_bo", 32'(if8.bo), 32'd0);
        @(posedge clk);

        // Reset in the middle of RUN aborts with no result.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd5; if8.b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(if8.busy), 32'd0);
        chk("abort_done", 32'(if8.done), 32'd0);
        chk("abort_d", 32'(if8.d), 32'd0);
        chk("abort_bo", 32'(if8.bo), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (if8.done === 1'b1 || if8.busy === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_d_after", 32'(if8.d), 32'd0);

        // Exhaustive WIDTH=4 sweep against a reference model.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                ea  = 4'(ai - bi);
                eb4 = (ai < bi) ? 4'd1 : 4'd0;
                @(negedge clk);
                if4.start = 1'b1; if4.a = 4'(ai); if4.b = 4'(bi);
                @(posedge clk);
                @(negedge clk);
                if4.start = 1'b0; if4.a = 4'(~ai); if4.b = 4'(bi + 5);
                got = 0;
                for (int k = 1; k <= 10; k++) begin
                    @(posedge clk); #1;
                    if (if4.done === 1'b1) begin
                        got = k;
                        break;
                    end
                end
                chk($sformatf("w4_lat_%0d_%0d", ai, bi), 32'(got), 32'd4);
                chk($sformatf("w4_d_%0d_%0d", ai, bi), 32'(if4.d), 32'(ea));
                chk($sformatf("w4_bo_%0d_%0d", ai, bi), 32'(if4.bo), 32'(eb4[0]));
                @(posedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
